lsu: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the RV32I core: it takes the effective address computed by the ALU (`o_alu_data` of the ALU, operand A = rs1, operand B = immediate, op = ADD) together with rs2 and funct3. It performs byte/half/word accesses over a valid/ready data-memory bus, stalling the core until the access completes. It returns aligned, sign- or zero-extended load data for writeback.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_if.sv | 22 ++
 rtl/lsu_load_extend.sv | 33 +++
 rtl/lsu.sv | 147 ++++++++++++++
 tb/tb_lsu.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type, timeout default and lane helpers for the LSU
// Contents: F3_* access-size codes, lsu_state_e, DEFAULT_TIMEOUT, is_misaligned()
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Size comes from funct3[1:0] only: 00 byte, 01 half, 1x word.
    // This also folds 011/110/111 into word and makes stores ignore bit 2.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - valid/ready data-memory bus between the LSU and memory
// master: LSU side (drives o_mem_*), slave: memory side (drives i_mem_*)
interface lsu_if;
    logic        o_mem_valid;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport master (
        output o_mem_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata
    );

    modport slave (
        input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - load lane select with sign/zero extension
// Ports: i_rdata (read word), i_addr_lo (byte offset), i_funct3 (load type), o_result (writeback value)
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'b0, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'b0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: byte/half/word accesses over a valid/ready memory bus
// Ports: i_clk, i_reset (sync, active-high); core side i_lsu_addr, i_st_data, i_funct3, i_rden, i_wren,
//        o_ld_data, o_ld_valid, o_stall, o_misaligned, o_bus_err; memory side via lsu_if.master mem
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_funct3,
    input  logic        i_rden,
    input  logic        i_wren,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    lsu_if.master       mem
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_ld_data;
    logic        r_err;

    logic        w_req, w_mis, w_start, w_abort, w_expired;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ext;

    assign w_req     = i_rden | i_wren;
    assign w_mis     = is_misaligned(i_funct3[1:0], i_lsu_addr[1:0]);
    assign w_start   = (r_state == ST_IDLE) && w_req && !w_mis;
    assign w_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Request cycle itself is stalled so the core holds the instruction.
    assign o_stall      = w_start || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign o_misaligned = (r_state == ST_IDLE) && w_req && w_mis;
    assign o_ld_valid   = (r_state == ST_DONE) && !r_we && !r_err;
    assign o_bus_err    = (r_state == ST_DONE) && r_err;
    assign o_ld_data    = r_ld_data;

    assign mem.o_mem_valid = (r_state == ST_REQ);
    assign mem.o_mem_we    = r_we;
    assign mem.o_mem_addr  = r_addr;
    assign mem.o_mem_be    = r_be;
    assign mem.o_mem_wdata = r_wdata;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_lsu_addr[1:0];
                w_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                w_be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_extend u_extend (
        .i_rdata   (mem.i_mem_rdata),
        .i_addr_lo (r_off),
        .i_funct3  (r_funct3),
        .o_result  (w_ext)
    );

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_REQ;
            ST_REQ: begin
                if (mem.i_mem_ready) begin
                    w_next = r_we ? ST_DONE : ST_WAIT;
                end else if (w_expired) begin
                    w_next  = ST_DONE;
                    w_abort = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem.i_mem_rvalid) begin
                    w_next = ST_DONE;
                end else if (w_expired) begin
                    w_next  = ST_DONE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_off     <= '0;
            r_funct3  <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_ld_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr   <= {i_lsu_addr[31:2], 2'b00};
                        r_off    <= i_lsu_addr[1:0];
                        r_funct3 <= i_funct3;
                        r_we     <= i_wren;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_cnt    <= '0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_abort) begin
                        r_err     <= 1'b1;
                        r_ld_data <= '0;
                    end else if (r_state == ST_WAIT && mem.i_mem_rvalid) begin
                        r_ld_data <= w_ext;
                    end
                end
                default: r_err <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lsu_addr, st_data;
    logic [2:0]  funct3;
    logic        rden, wren;
    logic [31:0] ld_data;
    logic        ld_valid, stall, misaligned, bus_err;
    int          checks = 0;
    int          failures = 0;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_lsu_addr   (lsu_addr),
        .i_st_data    (st_data),
        .i_funct3     (funct3),
        .i_rden       (rden),
        .i_wren       (wren),
        .o_ld_data    (ld_data),
        .o_ld_valid   (ld_valid),
        .o_stall      (stall),
        .o_misaligned (misaligned),
        .o_bus_err    (bus_err),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld_data"}, ld_data, 32'h0);
        chk({tag, "_ld_valid"}, {31'b0, ld_valid}, 32'h0);
        chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
        chk({tag, "_misaligned"}, {31'b0, misaligned}, 32'h0);
        chk({tag, "_bus_err"}, {31'b0, bus_err}, 32'h0);
        chk({tag, "_mem_valid"}, {31'b0, bus.o_mem_valid}, 32'h0);
        chk({tag, "_mem_we"}, {31'b0, bus.o_mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, bus.o_mem_addr, 32'h0);
        chk({tag, "_mem_be"}, {28'b0, bus.o_mem_be}, 32'h0);
        chk({tag, "_mem_wdata"}, bus.o_mem_wdata, 32'h0);
    endtask

    // Store; ready withheld for 'hold' REQ cycles, then accepted.
    task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] d, input logic [31:0] ea, input logic [3:0] ebe,
                            input logic [31:0] ewd, input int hold);
        lsu_addr = a; st_data = d; funct3 = f3; wren = 1'b1;
        bus.i_mem_ready = 1'b0;
        smp();
        chk({tag, "_c0_stall"}, {31'b0, stall}, 32'h1);
        chk({tag, "_c0_valid"}, {31'b0, bus.o_mem_valid}, 32'h0);
        cyc();
        for (int k = 0; k < hold; k++) begin
            smp();
            chk({tag, "_hold_valid"}, {31'b0, bus.o_mem_valid}, 32'h1);
            chk({tag, "_hold_addr"}, bus.o_mem_addr, ea);
            chk({tag, "_hold_be"}, {28'b0, bus.o_mem_be}, {28'b0, ebe});
            chk({tag, "_hold_wdata"}, bus.o_mem_wdata, ewd);
            chk({tag, "_hold_stall"}, {31'b0, stall}, 32'h1);
            cyc();
        end
        bus.i_mem_ready = 1'b1;
        smp();
        chk({tag, "_req_valid"}, {31'b0, bus.o_mem_valid}, 32'h1);
        chk({tag, "_req_we"}, {31'b0, bus.o_mem_we}, 32'h1);
        chk({tag, "_req_addr"}, bus.o_mem_addr, ea);
        chk({tag, "_req_be"}, {28'b0, bus.o_mem_be}, {28'b0, ebe});
        chk({tag, "_req_wdata"}, bus.o_mem_wdata, ewd);
        chk({tag, "_req_stall"}, {31'b0, stall}, 32'h1);
        cyc();
        bus.i_mem_ready = 1'b0;
        smp();
        chk({tag, "_done_stall"}, {31'b0, stall}, 32'h0);
        chk({tag, "_done_valid"}, {31'b0, bus.o_mem_valid}, 32'h0);
        chk({tag, "_done_ldv"}, {31'b0, ld_valid}, 32'h0);
        chk({tag, "_done_err"}, {31'b0, bus_err}, 32'h0);
        wren = 1'b0;
        cyc();
    endtask

    // Load; ready in first REQ cycle, rvalid in the following cycle.
    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] ea, input logic [31:0] exp);
        lsu_addr = a; funct3 = f3; rden = 1'b1;
        smp();
        chk({tag, "_c0_stall"}, {31'b0, stall}, 32'h1);
        chk({tag, "_c0_ldv"}, {31'b0, ld_valid}, 32'h0);
        cyc();
        bus.i_mem_ready = 1'b1;
        smp();
        chk({tag, "_c1_valid"}, {31'b0, bus.o_mem_valid}, 32'h1);
        chk({tag, "_c1_we"}, {31'b0, bus.o_mem_we}, 32'h0);
        chk({tag, "_c1_addr"}, bus.o_mem_addr, ea);
        chk({tag, "_c1_ldv"}, {31'b0, ld_valid}, 32'h0);
        cyc();
        bus.i_mem_ready = 1'b0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata = rdata;
        smp();
        chk({tag, "_c2_valid"}, {31'b0, bus.o_mem_valid}, 32'h0);
        chk({tag, "_c2_stall"}, {31'b0, stall}, 32'h1);
        chk({tag, "_c2_ldv"}, {31'b0, ld_valid}, 32'h0);
        cyc();
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata = 32'h0;
        smp();
        chk({tag, "_c3_ldv"}, {31'b0, ld_valid}, 32'h1);
        chk({tag, "_c3_data"}, ld_data, exp);
        chk({tag, "_c3_stall"}, {31'b0, stall}, 32'h0);
        rden = 1'b0;
        cyc();
        smp();
        chk({tag, "_c4_ldv"}, {31'b0, ld_valid}, 32'h0);
        chk({tag, "_c4_hold"}, ld_data, exp);
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        lsu_addr = 32'h0; st_data = 32'h0; funct3 = 3'b0; rden = 1'b0; wren = 1'b0;
        bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = 32'h0;
        cyc();
        cyc();
        smp();
        chk_all_zero("reset");
        cyc();
        reset = 1'b0;

        do_store("sb", 32'h0000_1003, F3_B, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 0);
        do_store("sh", 32'h0000_1002, F3_H, 32'h1234_BEEF, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 0);

        do_load("lb",  32'h0000_2001, F3_B,  32'h1234_80FF, 32'h0000_2000, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_2001, F3_BU, 32'h1234_80FF, 32'h0000_2000, 32'h0000_0080);
        do_load("lh",  32'h0000_3002, F3_H,  32'h8001_0000, 32'h0000_3000, 32'hFFFF_8001);
        do_load("lhu", 32'h0000_3002, F3_HU, 32'h8001_0000, 32'h0000_3000, 32'h0000_8001);
        do_load("lw",  32'h0000_3004, F3_W,  32'hCAFE_F00D, 32'h0000_3004, 32'hCAFE_F00D);

        // Misaligned word load: flagged, no stall, no bus request, stays idle.
        lsu_addr = 32'h0000_3002; funct3 = F3_W; rden = 1'b1;
        smp();
        chk("lw_mis_flag", {31'b0, misaligned}, 32'h1);
        chk("lw_mis_stall", {31'b0, stall}, 32'h0);
        chk("lw_mis_valid", {31'b0, bus.o_mem_valid}, 32'h0);
        cyc();
        smp();
        chk("lw_mis_flag2", {31'b0, misaligned}, 32'h1);
        chk("lw_mis_valid2", {31'b0, bus.o_mem_valid}, 32'h0);
        chk("lw_mis_stall2", {31'b0, stall}, 32'h0);
        rden = 1'b0;
        cyc();
        smp();
        chk("mis_clear", {31'b0, misaligned}, 32'h0);
        cyc();

        do_store("sw_hold", 32'h0000_4008, F3_W, 32'hDEAD_BEEF, 32'h0000_4008, 4'b1111, 32'hDEAD_BEEF, 5);

        // Reset while waiting for read data aborts the access.
        lsu_addr = 32'h0000_6000; funct3 = F3_W; rden = 1'b1;
        cyc();
        bus.i_mem_ready = 1'b1;
        cyc();
        bus.i_mem_ready = 1'b0;
        smp();
        chk("rst_wait_stall", {31'b0, stall}, 32'h1);
        chk("rst_wait_ld_data_pre", ld_data, 32'hCAFE_F00D);
        reset = 1'b1;
        rden = 1'b0;
        cyc();
        reset = 1'b0;
        smp();
        chk_all_zero("rst_wait");
        cyc();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata = 32'h5555_AAAA;
        smp();
        chk("stray_ldv", {31'b0, ld_valid}, 32'h0);
        chk("stray_stall", {31'b0, stall}, 32'h0);
        cyc();
        bus.i_mem_rvalid = 1'b0;
        smp();
        chk("stray_ldv2", {31'b0, ld_valid}, 32'h0);
        chk("stray_data", ld_data, 32'h0);
        cyc();

        // Preload a nonzero result so the timeout clearing it is visible.
        do_load("lw_pre", 32'h0000_7000, F3_W, 32'h0BAD_F00D, 32'h0000_7000, 32'h0BAD_F00D);

        // Timeout with TIMEOUT_CYCLES=8: one REQ cycle plus seven WAIT cycles, then abort.
        lsu_addr = 32'h0000_5000; funct3 = F3_W; rden = 1'b1;
        smp();
        chk("to_c0_stall", {31'b0, stall}, 32'h1);
        cyc();
        bus.i_mem_ready = 1'b1;
        smp();
        chk("to_c1_stall", {31'b0, stall}, 32'h1);
        chk("to_c1_valid", {31'b0, bus.o_mem_valid}, 32'h1);
        cyc();
        bus.i_mem_ready = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            smp();
            chk("to_wait_stall", {31'b0, stall}, 32'h1);
            chk("to_wait_err", {31'b0, bus_err}, 32'h0);
            cyc();
        end
        smp();
        chk("to_err", {31'b0, bus_err}, 32'h1);
        chk("to_ldv", {31'b0, ld_valid}, 32'h0);
        chk("to_data", ld_data, 32'h0);
        chk("to_stall", {31'b0, stall}, 32'h0);
        rden = 1'b0;
        cyc();
        smp();
        chk("to_err_pulse", {31'b0, bus_err}, 32'h0);
        chk("to_idle_stall", {31'b0, stall}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
